vic_irq: RTL

//  Interrupt request collector/arbiter directly upstream of the VIC controller.

---
 rtl/vic_irq_pkg.sv | 7 +
 rtl/vic_irq_if.sv | 24 ++
 rtl/vic_prio_enc.sv | 17 +
 rtl/vic_irq.sv | 91 +++++++++
 4 files changed

// File: rtl/vic_irq_pkg.sv
// Shared types and limits for the VIC interrupt collector.
package vic_pkg;
    localparam int VIC_ISR_W   = 5;
    localparam int VIC_MAX_SRC = 32;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} vic_state_e;
endpackage

// File: rtl/vic_irq_if.sv
// Request/status bundle between peripheral side (master) and the collector (slave).
interface vic_irq_if #(
    parameter int N_SRC = 8,
    parameter int ISR_W = 5
);
    logic [N_SRC-1:0] i_irq_src;
    logic             i_mask_we;
    logic [N_SRC-1:0] i_mask_wdata;
    logic             i_reti;
    logic             o_IRQ;
    logic [ISR_W-1:0] o_ISR_addr;
    logic [N_SRC-1:0] o_pending;
    logic [N_SRC-1:0] o_mask;
    logic             o_busy;

    modport master (
        output i_irq_src, i_mask_we, i_mask_wdata, i_reti,
        input  o_IRQ, o_ISR_addr, o_pending, o_mask, o_busy
    );
    modport slave (
        input  i_irq_src, i_mask_we, i_mask_wdata, i_reti,
        output o_IRQ, o_ISR_addr, o_pending, o_mask, o_busy
    );
endinterface

// File: rtl/vic_prio_enc.sv
// Priority encoder: lowest set request index wins; idx is zero-extended.
module vic_prio_enc #(
    parameter int N = 8,
    parameter int W = 5
) (
    input  logic [N-1:0] req_i,
    output logic         vld_o,
    output logic [W-1:0] idx_o
);
    always_comb begin
        vld_o = |req_i;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
        end
    end
endmodule

// File: rtl/vic_irq.sv
// Interrupt collector/arbiter: edge detect, pending, mask, priority grant, IRQ held until reti.
// Optional VIC_IRQ_SYNC_EN adds a 2-flop synchronizer per source line.
module vic_irq
    import vic_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int ISR_W = VIC_ISR_W
) (
    input logic      clk,
    input logic      rst,
    vic_irq_if.slave bus
);
    logic [N_SRC-1:0] src_s, src_q, mask_q, mask_d, pend_q, pend_d;
    logic [N_SRC-1:0] set_v, clr_v, elig;
    logic [ISR_W-1:0] addr_q, addr_d, win;
    logic             win_vld, reti_q, reti_rise, grant;
    vic_state_e       state_q, state_d;

`ifdef VIC_IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.i_irq_src;
            sync2_q <= sync1_q;
        end
    end
    assign src_s = sync2_q;
`else
    assign src_s = bus.i_irq_src;
`endif

    // Drop check uses the mask being written this cycle, if any.
    assign mask_d    = bus.i_mask_we ? bus.i_mask_wdata : mask_q;
    assign set_v     = src_s & ~src_q & mask_d;
    assign elig      = pend_q & mask_q;
    assign reti_rise = bus.i_reti & ~reti_q;
    assign grant     = (state_q != ACTIVE) && win_vld;
    // Set wins over clear for a fresh edge on the source being granted.
    assign pend_d    = (pend_q & ~clr_v) | set_v;

    vic_prio_enc #(.N(N_SRC), .W(ISR_W)) u_enc (
        .req_i (elig),
        .vld_o (win_vld),
        .idx_o (win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            reti_q  <= 1'b0;
            mask_q  <= '0;
            pend_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_s;
            reti_q  <= bus.i_reti;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, GAP: state_d = win_vld ? ACTIVE : IDLE;
            ACTIVE:    if (reti_rise) state_d = GAP;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        clr_v  = '0;
        if (grant) begin
            addr_d = win;
            clr_v  = N_SRC'(1) << win;
        end
    end

    assign bus.o_IRQ      = (state_q == ACTIVE);
    assign bus.o_busy     = (state_q == ACTIVE);
    assign bus.o_ISR_addr = addr_q;
    assign bus.o_pending  = pend_q;
    assign bus.o_mask     = mask_q;
endmodule
